// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer between the UART receiver and the core's UART
// data register. Bytes are held in a circular FIFO until the core reads them.
// The FIFO provides an empty marker, its occupancy and a sticky overflow flag.
//
// Optional feature: define UART_RX_FIFO_WM_EN to add the watermark output wm,
// which is asserted while level >= WATERMARK.
//
// Ports:
//   r_clk     system clock, rising edge
//   rst_n     synchronous active-low reset (pointers, level, overflow)
//   in_data   received byte
//   in_valid  push strobe for in_data
//   rd_en     pop strobe (bus read of the data register)
//   rd_data   show-ahead head byte zero-extended; all ones when empty
//   empty     level == 0
//   full      level == DEPTH
//   level     current occupancy, 0..DEPTH
//   overflow  sticky, set when a byte was dropped
//   clr_ovf   strobe that clears overflow (a same-cycle set wins)
//   wm        level >= WATERMARK (only with UART_RX_FIFO_WM_EN)
module uart_rx_fifo #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AW        = 4,
   parameter int unsigned WATERMARK = 8
) (
   input  logic          r_clk,
   input  logic          rst_n,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   input  logic          rd_en,
   output logic [31:0]   rd_data,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   level,
   output logic          overflow,
   input  logic          clr_ovf
`ifdef UART_RX_FIFO_WM_EN
   ,
   output logic          wm
`endif
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          push;
   logic          pop;
   logic          drop;

   if (DEPTH < 2 || DEPTH != (1 << AW)) begin : g_depth_chk
      $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and equal 2**AW");
   end

   assign empty = (level == '0);
   assign full  = (level == FULL_LVL);

   // A pop can only happen when the FIFO is not empty. Because DEPTH >= 2, the
   // FIFO is never empty when it is full. So a push into a full FIFO that pops
   // in the same cycle reuses the slot the pop frees.
   assign pop  = rd_en && !empty;
   assign push = in_valid && (!full || pop);
   assign drop = in_valid && full && !pop;

   assign rd_data = empty ? '1 : {24'b0, mem[rp]};

   // The storage has no reset. After a reset, stale contents are never
   // visible because level is 0.
   always_ff @(posedge r_clk) begin
      if (push) begin
         mem[wp] <= in_data;
      end
   end

   always_ff @(posedge r_clk) begin
      if (!rst_n) begin
         wp       <= '0;
         rp       <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wp <= wp + 1'b1;
         end
         if (pop) begin
            rp <= rp + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

`ifdef UART_RX_FIFO_WM_EN
   localparam logic [AW:0] WM_LVL = (AW+1)'(WATERMARK);

   if (WATERMARK < 1 || WATERMARK > DEPTH) begin : g_wm_chk
      $error("uart_rx_fifo: WATERMARK must be in 1..DEPTH");
   end

   assign wm = (level >= WM_LVL);
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the `uart` receiver and the core's memory-mapped UART data register at `0x01000004`. It captures every byte the receiver delivers and holds it in a circular FIFO until the core reads it, so back-to-back bytes are not lost while firmware is busy. It reports an empty marker, occupancy and a sticky overflow flag, which feed the system status word at `0x01000000`.

## Interface
- `DEPTH`, 16, number of byte entries; power of two, minimum 2.
- `AW`, 4, pointer width; must equal log2(`DEPTH`).
- `WATERMARK`, 8, level threshold for `wm`; only used with `UART_RX_FIFO_WM_EN`; legal range 1..`DEPTH`.

- `r_clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data`  in  8  received byte from the UART receiver.
- `in_valid`  in  1  one-cycle strobe; `in_data` is valid and is pushed this edge.
- `rd_en`  in  1  pop strobe, driven by the bus read of `0x01000004`.
- `rd_data`  out  32  head byte zero-extended to 32 bits; `32'hFFFFFFFF` when empty.
- `empty`  out  1  level == 0.
- `full`  out  1  level == `DEPTH`.
- `level`  out  AW+1  current occupancy, 0..`DEPTH`.
- `overflow`  out  1  sticky; set when a byte was dropped.
- `clr_ovf`  in  1  one-cycle strobe that clears `overflow`.
- `wm`  out  1  level >= `WATERMARK`; present only with `UART_RX_FIFO_WM_EN`.

## Operation
- Storage is `DEPTH` x 8 registers with write pointer `wp` and read pointer `rp` (each AW bits, wrapping modulo `DEPTH`) and an occupancy counter `level` (AW+1 bits).
- Push: `in_valid` && (!`full` || pop this cycle) writes `mem[wp]`, then `wp` increments.
- Pop: `rd_en` && !`empty` increments `rp`. `rd_en` while empty is a no-op.
- `level` update:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- Full with simultaneous push and pop: both take effect, `level` stays at `DEPTH`, no overflow.
- Empty with simultaneous push and pop: the pop is ignored, the push takes effect, `level` becomes 1.
- Overflow: `in_valid` && `full` && no pop drops the byte. Pointers and contents are unchanged and `overflow` is set.
- `overflow` set and `clr_ovf` in the same cycle: set wins, and `overflow` stays 1.
- `rd_data` is show-ahead: `{24'b0, mem[rp]}` when !`empty`, else `32'hFFFFFFFF`. It is combinational from registered state. This keeps firmware's "data available" test (`rd_data != ~0`) valid.
- Reset (`rst_n` low at an edge): `wp`=0, `rp`=0, `level`=0, `overflow`=0. Memory contents are not cleared. Reset overrides any push or pop in the same cycle, and a reset mid-stream discards all buffered bytes.

## Timing
- Values after reset: `empty`=1, `full`=0, `level`=0, `overflow`=0, `rd_data`=`32'hFFFFFFFF`, `wm`=0.
- Push latency: a byte strobed at edge N is visible on `rd_data` and counted in `level` after edge N.
- Pop latency: after a pop at edge N, the next byte (or `~0`) appears on `rd_data` after edge N.
- The bus samples `rd_data` in the same cycle it asserts `rd_en`, so the popped value is the pre-edge head.
- `rd_en` and `in_valid` are treated as per-cycle strobes. A strobe held for k cycles acts as k operations; upstream blocks guarantee single-cycle pulses.
- `empty`, `full`, `wm` and `overflow` are all derived from registered state, with no combinational path from the inputs.

## Configuration
- `UART_RX_FIFO_WM_EN` defined:
  - `wm` port exists and is asserted whenever `level` >= `WATERMARK`.
  - `wm` is mapped to status bit 6.
- `UART_RX_FIFO_WM_EN` undefined:
  - `wm` port, the comparator and the `WATERMARK` checks are absent.
  - Status bit 6 reads 0.
  - All other behaviour is identical.

## Test plan
- Reset, then push `0x41`, `0x42`, `0x43` on consecutive cycles -> `level`=3 and `rd_data`=`0x00000041`. Three pops return `0x41`, `0x42`, `0x43`, then `rd_data`=`0xFFFFFFFF` and `empty`=1.
- Push 16 bytes `0x00`..`0x0F` (`DEPTH`=16) -> `full`=1, `level`=16. A 17th push of `0xAA` sets `overflow`=1, `level` stays 16, and draining returns `0x00`..`0x0F` with no `0xAA`.
- While full, push `0x55` and pop in the same cycle -> `level`=16, `overflow`=0, and `0x55` is the last byte drained.
- While empty, push `0x7E` and pop in the same cycle -> `level`=1, `rd_data`=`0x0000007E`. A `rd_en` while empty leaves all state unchanged.
- Wrap-around: repeat 40 push/pop pairs with incrementing data -> every byte is returned in order and `level` never exceeds 1. Assert `clr_ovf` together with an overflowing push -> `overflow` remains 1; `clr_ovf` alone on the next cycle -> 0.
- With `UART_RX_FIFO_WM_EN` and `WATERMARK`=8: after 7 pushes `wm`=0; after the 8th `wm`=1; one pop -> `wm`=0. Assert reset with 5 bytes buffered -> `level`=0, `empty`=1, `wm`=0 after the edge.
